// File: rtl/tenbaset_pkg.sv
// Shared types and 20 MHz timing constants for the 10BASE-T transmit scheduler.
package tenbaset_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BUSY = 3'd1,
        XMIT      = 3'd2,
        IFG       = 3'd3,
        NLP       = 3'd4
    } state_t;

    localparam int IFG_CYCLES_20M    = 192;
    localparam int NLP_PERIOD_20M    = 320000;
    localparam int NLP_WIDTH_20M     = 2;
    localparam int START_TIMEOUT_DEF = 16;

    localparam int NLP_TIMER_W = $clog2(NLP_PERIOD_20M);
    localparam int CNT_W       = 8;

endpackage

// File: rtl/tenbaset_rr_arb.sv
// Two-way round-robin pick; the source that was not served last wins a tie.
module tenbaset_rr_arb (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] grant,
    output logic       idx
);

    always_comb begin
        idx = 1'b0;
        unique case (req)
            2'b01:   idx = 1'b0;
            2'b10:   idx = 1'b1;
            2'b11:   idx = ~rr_last;
            default: idx = 1'b0;
        endcase
        grant = 2'b00;
        if (|req) begin
            grant = idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/tenbaset_tx_sched.sv
// Shares one Manchester transmitter between two frame sources and keeps the
// link alive with Normal Link Pulses when the line is quiet.
module tenbaset_tx_sched
    import tenbaset_pkg::*;
#(
    parameter int IFG_CYCLES    = IFG_CYCLES_20M,
    parameter int NLP_PERIOD    = NLP_PERIOD_20M,
    parameter int NLP_WIDTH     = NLP_WIDTH_20M,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       tx_sel,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       nlp,
    output logic       start_err
);

    localparam logic [NLP_TIMER_W-1:0] TMR_LAST = NLP_TIMER_W'(NLP_PERIOD - 1);
    localparam logic [CNT_W-1:0]       IFG_LAST = CNT_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0]       NLP_LAST = CNT_W'(NLP_WIDTH - 1);
    localparam logic [CNT_W-1:0]       TO_LAST  = CNT_W'(START_TIMEOUT - 1);

    state_t                 state;
    logic [NLP_TIMER_W-1:0] nlp_timer;
    logic [CNT_W-1:0]       cnt;
    logic                   rr_last;
    logic [1:0]             arb_grant;
    logic                   arb_idx;

    tenbaset_rr_arb u_arb (
        .req     (req),
        .rr_last (rr_last),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            grant     <= 2'b00;
            tx_sel    <= 1'b0;
            tx_start  <= 1'b0;
            nlp       <= 1'b0;
            start_err <= 1'b0;
            nlp_timer <= '0;
            cnt       <= '0;
            rr_last   <= 1'b1;
        end else begin
            tx_start  <= 1'b0;
            start_err <= 1'b0;
            if (nlp_timer != TMR_LAST) begin
                nlp_timer <= nlp_timer + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    // A pending frame beats an expiring link-pulse timer.
                    if (|req) begin
                        grant    <= arb_grant;
                        tx_sel   <= arb_idx;
                        tx_start <= 1'b1;
                        cnt      <= '0;
                        state    <= WAIT_BUSY;
                    end else if (nlp_timer == TMR_LAST) begin
                        nlp       <= 1'b1;
                        nlp_timer <= '0;
                        cnt       <= '0;
                        state     <= NLP;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= XMIT;
                    end else if (cnt == TO_LAST) begin
                        start_err <= 1'b1;
                        grant     <= 2'b00;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XMIT: begin
                    if (!tx_busy) begin
                        grant     <= 2'b00;
                        rr_last   <= tx_sel;
                        nlp_timer <= '0;
                        cnt       <= '0;
                        state     <= IFG;
                    end
                end
                IFG: begin
                    if (cnt == IFG_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NLP: begin
                    if (cnt == NLP_LAST) begin
                        nlp   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tenbaset_tx_sched.md
# tenbaset_tx_sched

Transmit scheduler for the 20 MHz 10BASE-T transmit path. It shares one Manchester transmitter between two frame sources using round-robin arbitration. It sequences each frame as start, busy, then inter-frame gap. When the line is quiet, it issues Normal Link Pulses (NLP) so the link partner keeps the link up. It sits between the frame generators and the transmitter, and runs in the PLL clock domain.

## Interface
- IFG_CYCLES, 192, inter-frame gap in clocks (9.6 µs at 20 MHz)
- NLP_PERIOD, 320000, NLP repetition period in clocks (16 ms)
- NLP_WIDTH, 2, NLP high time in clocks (100 ns)
- START_TIMEOUT, 16, clocks to wait for tx_busy after tx_start
- CLK  in  1  20 MHz PLL clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req  in  2  per-source frame request, level; bit i = source i
- grant  out  2  one-hot grant, held from start until frame end
- tx_sel  out  1  index of granted source, drives transmitter data mux
- tx_start  out  1  one-cycle pulse: transmitter begins frame
- tx_busy  in  1  transmitter serializing, including TP_IDL
- nlp  out  1  link-pulse request to line driver (TD+ high, TD− low)
- start_err  out  1  one-cycle pulse: tx_busy never rose

## Operation
- Reset values: grant=00, tx_sel=0, tx_start=0, nlp=0, start_err=0, state=IDLE, nlp_timer=0, rr_last=1 (source 0 wins the first tie).
- States and transitions:
  - IDLE:
    - If any req bit is set: arbitrate, set grant/tx_sel, pulse tx_start, go to WAIT_BUSY.
    - Otherwise, if nlp_timer==NLP_PERIOD-1: go to NLP.
  - WAIT_BUSY: on tx_busy=1, go to XMIT. If START_TIMEOUT clocks pass without tx_busy: pulse start_err, clear grant, go to IDLE. No gap is inserted and rr_last is not updated.
  - XMIT: on tx_busy=0, clear grant, set rr_last to the served source, clear nlp_timer, go to IFG.
  - IFG: count IFG_CYCLES clocks, then go to IDLE. Requests are ignored during the gap.
  - NLP: drive nlp=1 for exactly NLP_WIDTH clocks, then go to IDLE. nlp_timer is cleared on entry.
- Arbitration:
  - One requester: it wins.
  - Both requesting: the source ≠ rr_last wins.
  - req is sampled only in IDLE. Dropping req after grant has no effect; grant holds until the frame ends.
- nlp_timer:
  - 19 bits, increments every clock and saturates at NLP_PERIOD-1.
  - Cleared on NLP entry and at frame end.
  - If it saturates outside IDLE, the NLP fires on the first IDLE cycle with no request.
- Simultaneous req and NLP expiry in IDLE: the frame wins and nlp stays 0. The frame itself acts as link activity and clears the timer at its end.
- tx_busy high while in IDLE, IFG or NLP: ignored. Transmitter faults are not this block's concern.
- RST mid-frame or mid-NLP: all outputs return to reset values on the next edge. The transmitter is reset by the same RST.

## Timing
- All outputs are registered.
- A req seen at edge N in IDLE gives grant, tx_sel and tx_start=1 after edge N. tx_start falls after edge N+1.
- tx_busy falling seen at edge M gives grant=00 after edge M. The earliest next tx_start follows edge M+IFG_CYCLES+1.
- Idle line with no requests: nlp rises NLP_PERIOD clocks after reset release. It then repeats every NLP_PERIOD clocks, rising edge to rising edge.
- grant is never active while nlp=1. nlp and tx_start are never high in the same cycle.

## Structure
- Package tenbaset_pkg holds:
  - the state enum (IDLE, WAIT_BUSY, XMIT, IFG, NLP);
  - the 20 MHz timing constants (IFG_CYCLES, NLP_PERIOD, NLP_WIDTH) used as parameter defaults;
  - the NLP timer width, computed with $clog2.
- Sub-module tenbaset_rr_arb: combinational 2-way round-robin pick from req and rr_last. It outputs a one-hot grant and the winning index.
- The FSM, timers and registers live in tenbaset_tx_sched.

## Test plan
Use NLP_PERIOD=1000 for scenarios 3 and 5.
1. Single frame:
   - Stimulus: release reset, req=01, tx_busy high for 100 cycles starting 3 cycles after tx_start.
   - Response: one tx_start pulse with tx_sel=0 and grant=01. grant=00 one cycle after tx_busy falls. No tx_start for the following 192 cycles, even with req held.
2. Round-robin: req=11 held, each frame 50 busy cycles → grants alternate 01, 10, 01, 10, each separated by 192 gap cycles.
3. NLP generation: no requests → nlp high for exactly 2 cycles, first rising 1000 cycles after reset, then every 1000 cycles. grant stays 00 throughout.
4. Start timeout: req=10, tx_busy held 0 → start_err pulses 16 cycles after tx_start and grant clears. The next tx_start for source 1 follows 1 cycle later, with no gap.
5. NLP collision: req=01 raised in the same cycle nlp_timer reaches 999 → frame granted and nlp stays 0. After the frame, the next nlp rises 1000 cycles after tx_busy falls.
6. Reset mid-frame: RST asserted for 1 cycle during XMIT → grant=00, nlp=0, tx_start=0 on the next edge. The state after release is IDLE and source 0 wins a following req=11.
